// File: rtl/bit_serializer_pkg.sv
// Shared constants for the serializer and its downstream sequence detector.
// Both the RTL and the benches import this package.
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: takes WIDTH-bit words over valid/ready and emits
// them one bit per clock. A single holding register keeps back-to-back words gapless.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, hold, shifted;
  logic             hold_full;
  logic [CW-1:0]    bitcnt;
  logic             accept, last_bit;

  // in_ready comes only from hold_full, so there is no path from in_valid.
  assign accept   = in_valid & ~hold_full;
  assign last_bit = (bitcnt == LAST);
  assign shifted  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit && !hold_full && !accept) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = ~hold_full;
    ser_valid   = (state == ST_SHIFT);
    ser_data    = IDLE_BIT;
    if (ser_valid) ser_data = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    frame_start = ser_valid && (bitcnt == '0);
    busy        = ser_valid || hold_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bitcnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg  <= in_word;
            bitcnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            shreg  <= shifted;
            bitcnt <= bitcnt + 1'b1;
            if (accept) begin
              hold      <= in_word;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            shreg     <= hold;
            hold_full <= 1'b0;
            bitcnt    <= '0;
          end else if (accept) begin
            // direct reload: the next word starts with no idle cycle
            shreg  <= in_word;
            bitcnt <= '0;
          end else begin
            bitcnt <= '0;
          end
        end
        default: bitcnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: default 8-bit MSB-first instance plus a
// 4-bit LSB-first instance with idle level 1.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       v8, r8, d8, sv8, fs8, b8;
  logic [7:0] w8;
  logic       v4, r4, d4, sv4, fs4, b4;
  logic [3:0] w4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_word(w8),
    .ser_data(d8), .ser_valid(sv8), .frame_start(fs8), .busy(b8)
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_word(w4),
    .ser_data(d4), .ser_valid(sv4), .frame_start(fs4), .busy(b4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, "_valid"}, sv8, 0);
    chk({tag, "_data"},  d8,  0);
    chk({tag, "_fs"},    fs8, 0);
    chk({tag, "_busy"},  b8,  0);
    chk({tag, "_ready"}, r8,  1);
  endtask

  // Three words with in_valid held high; words 2 and 3 each wait in the hold register.
  task automatic run_stream(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input string tag);
    logic [23:0] s;
    s  = {a, b, c};
    v8 = 1'b1;
    w8 = a;
    tick();
    for (int n = 1; n <= 24; n++) begin
      chk($sformatf("%s_valid_c%0d", tag, n), sv8, 1);
      chk($sformatf("%s_data_c%0d", tag, n), d8, s[24-n]);
      chk($sformatf("%s_fs_c%0d", tag, n), fs8, (n == 1 || n == 9 || n == 17));
      chk($sformatf("%s_ready_c%0d", tag, n), r8, (n == 1 || n == 9 || n >= 17));
      if (n == 1)  w8 = b;
      if (n == 2)  w8 = c;
      if (n == 10) v8 = 1'b0;
      tick();
    end
    chk_idle8({tag, "_end"});
  endtask

  initial begin
    logic [7:0] word;
    logic [3:0] nib;
    rst = 1'b1; v8 = 1'b0; w8 = '0; v4 = 1'b0; w4 = '0;
    #2;
    chk_idle8("rst");
    chk("rst_data4", d4, 1);
    chk("rst_valid4", sv4, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single word, MSB first
    word = 8'hB5;
    v8 = 1'b1; w8 = word;
    tick();
    v8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b5_valid_%0d", i), sv8, 1);
      chk($sformatf("b5_data_%0d", i), d8, word[7-i]);
      chk($sformatf("b5_fs_%0d", i), fs8, (i == 0));
      tick();
    end
    chk_idle8("b5_end");

    run_stream(8'h3C, 8'hA5, 8'hFF, "strm");
    tick();
    // held 11 must survive in_word changing to 22 while not ready
    run_stream(8'hC3, 8'h11, 8'h22, "hold");
    tick();

    // reset during bit 3 with a word held
    word = 8'hF0;
    v8 = 1'b1; w8 = word;
    tick();
    w8 = 8'h0F;
    tick();
    v8 = 1'b0;
    chk("mid_busy", b8, 1);
    chk("mid_ready", r8, 0);
    tick(); tick();
    chk("mid_bit3", d8, word[4]);
    rst = 1'b1;
    #1;
    chk_idle8("mid_rst");
    tick();
    chk_idle8("mid_rst_hold");
    rst = 1'b0;
    word = 8'h5A;
    v8 = 1'b1; w8 = word;
    tick();
    v8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post_data_%0d", i), d8, word[7-i]);
      chk($sformatf("post_fs_%0d", i), fs8, (i == 0));
      tick();
    end
    chk_idle8("post_end");

    // 4-bit LSB-first instance, idle level 1
    nib = 4'b0001;
    v4 = 1'b1; w4 = nib;
    tick();
    v4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w4_valid_%0d", i), sv4, 1);
      chk($sformatf("w4_data_%0d", i), d4, nib[i]);
      chk($sformatf("w4_fs_%0d", i), fs4, (i == 0));
      tick();
    end
    chk("w4_idle_data", d4, 1);
    chk("w4_idle_valid", sv4, 0);
    chk("w4_idle_busy", b4, 0);

    // direct reload on the last-bit cycle with hold empty
    v8 = 1'b1; w8 = 8'h01;
    tick();
    v8 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("rl_last_data", d8, 1);
    chk("rl_last_ready", r8, 1);
    chk("rl_last_fs", fs8, 0);
    word = 8'h81;
    v8 = 1'b1; w8 = word;
    tick();
    v8 = 1'b0;
    chk("rl_next_fs", fs8, 1);
    chk("rl_next_valid", sv8, 1);
    chk("rl_next_data", d8, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("rl_data_%0d", i), d8, word[7-i]);
      chk($sformatf("rl_fs_%0d", i), fs8, 0);
    end
    tick();
    chk_idle8("rl_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage directly upstream of the sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock onto the detector's serial data input. A one-word holding register lets consecutive words stream with no idle cycles. While no word is being shifted, the serial line is driven to a fixed idle level.

Parameters:
WIDTH, 8, bits per word; must be 2 or more.
MSB_FIRST, 1, 1 shifts word bit WIDTH-1 first; 0 shifts bit 0 first.
IDLE_BIT, 0, level driven on ser_data while nothing is being shifted.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_word is valid this cycle.
in_ready  output  1  block can take a word this cycle.
in_word  input  WIDTH  parallel word; sampled only on an accept.
ser_data  output  1  serial bit; connects to the detector's in_data.
ser_valid  output  1  ser_data carries a word bit this cycle.
frame_start  output  1  high during the first bit of each word.
busy  output  1  a word is shifting or one is held.

Behaviour:
- Clock and reset
  - All registers use the asynchronous, active-high rst and update on the rising edge of clk.
  - Reset values: state=IDLE, hold_full=0, bitcnt=0, shreg=0.
  - Resulting outputs during and after reset: ser_data=IDLE_BIT, ser_valid=0, frame_start=0, busy=0, in_ready=1.
- Accept rule
  - accept = in_valid & in_ready, sampled at the rising edge.
  - in_ready = !hold_full. It is decoded only from registers, with no combinational path from in_valid.
- States (constants ST_IDLE, ST_SHIFT)
  - IDLE: on accept, shreg<=in_word, bitcnt<=0, and go to SHIFT. hold_full stays 0.
  - SHIFT, bitcnt < WIDTH-1:
    - Shift shreg toward the output end; bitcnt++.
    - On accept, hold<=in_word and hold_full<=1.
  - SHIFT, bitcnt == WIDTH-1 (last bit):
    - If hold_full: shreg<=hold, hold_full<=0, bitcnt<=0; stay in SHIFT. No accept is possible here because in_ready=0.
    - Else if accept: shreg<=in_word, bitcnt<=0; stay in SHIFT (direct reload).
    - Else: go to IDLE.
- Outputs
  - ser_valid = (state==SHIFT).
  - ser_data = SHIFT ? shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0) : IDLE_BIT.
  - frame_start = SHIFT & (bitcnt==0).
  - busy = (state==SHIFT) | hold_full.
- Latency and throughput
  - Latency: the first bit of a word accepted at edge k appears on ser_data in the cycle after edge k.
  - Each word occupies exactly WIDTH consecutive cycles.
  - With in_valid held high, the bit stream is gapless indefinitely.
- Boundary conditions
  - Hold register full: in_ready=0, and in_word changes are ignored.
  - Accept in the last-bit cycle with hold empty: the next word's first bit follows immediately, with no gap.
  - bitcnt width is clog2(WIDTH). It never exceeds WIDTH-1 and is reset to 0 on every load.
  - Reset mid-word: the word in shreg and any held word are discarded. Outputs are at reset values from the reset assertion onward.
  - The idle level is driven continuously, so downstream logic sees a defined bit every cycle.

Decomposition:
- Shared package holds:
  - state constants ST_IDLE and ST_SHIFT, with a state width of 1.
  - default WIDTH.
- The detector and serializer testbenches both use this package.
- No sub-module. The holding register and the shifter are small enough to live in a single module.

Test Plan:
- Reset, then accept 8'hB5 (MSB_FIRST=1) -> ser_data 1,0,1,1,0,1,0,1 in the 8 cycles after accept; ser_valid high for exactly 8 cycles; frame_start high in the first cycle only; then ser_data=0, busy=0.
- in_valid held high with 8'h3C, 8'hA5, 8'hFF -> 24 contiguous valid bits 00111100 10100101 11111111; frame_start at cycles 1, 9 and 17; in_ready low from the cycle after the second accept until the last bit of word 1.
- Hold register full, in_word changed from 8'h11 to 8'h22 while in_ready=0 -> 8'h22 is not serialized until it is accepted; the held word (8'h11) is output intact.
- rst asserted during bit 3 of a word, with a word held -> ser_valid=0, ser_data=IDLE_BIT, in_ready=1, busy=0 from assertion; after release, the next accepted word starts cleanly at bitcnt 0.
- WIDTH=4, MSB_FIRST=0, IDLE_BIT=1, word 4'b0001 -> ser_data 1,0,0,0, then idle at 1.
- Single word accepted exactly on the last-bit cycle with hold empty (direct reload) -> no gap; frame_start pulses in the very next cycle.
